// File: rtl/mole_pkg.sv
// mole_pkg: shared constants and types for the whack-a-mole LED game blocks.
//   N_LEDS        number of game LEDs
//   mole_state_t  game FSM state encoding
//   LFSR_*        width and feedback taps of the 5-bit game LFSR
//   window_len()  difficulty-scaled lit window, never shorter than one cycle
package mole_pkg;

    localparam int N_LEDS = 18;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PICK = 3'd1,
        SHOW = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } mole_state_t;

    // x^5 + x^3 + 1, Fibonacci form: feedback = q[4] ^ q[2], shifted in at bit 0.
    localparam int LFSR_W      = 5;
    localparam int LFSR_TAP_HI = 4;
    localparam int LFSR_TAP_LO = 2;

    function automatic logic [31:0] window_len(input logic [31:0] base, input logic [1:0] diff);
        logic [31:0] w;
        w = base >> diff;
        if (w == 32'd0) begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mole_led_generator_if.sv
// mole_led_generator_if: control inputs and game status outputs of the LED generator.
//   start        game start request (level or pulse), honoured only while idle or done
//   difficulty   lit window = SHOW_CYCLES >> difficulty, captured when a LED is chosen
//   leds         one-hot while a mole is shown, zero otherwise
//   round_active high exactly while leds is nonzero
//   new_round    one-cycle pulse on the first lit cycle of each round
//   round_num    completed rounds in the current game
//   game_over    high once the last round's gap has elapsed
//   fsm_state    debug view of the game FSM (mole_state_t encoding)
// There is no valid/ready pair: start is a plain level sampled on every clk
// edge, and every status output is registered and valid on every cycle.
interface mole_led_generator_if;
    logic                         start;
    logic [1:0]                   difficulty;
    logic [mole_pkg::N_LEDS-1:0]  leds;
    logic                         round_active;
    logic                         new_round;
    logic [3:0]                   round_num;
    logic                         game_over;
    logic [2:0]                   fsm_state;

    modport master (
        output start, difficulty,
        input  leds, round_active, new_round, round_num, game_over, fsm_state
    );

    modport slave (
        input  start, difficulty,
        output leds, round_active, new_round, round_num, game_over, fsm_state
    );
endinterface

// File: rtl/lfsr5.sv
// lfsr5: free-running 5-bit maximal-length LFSR (x^5+x^3+1, period 31).
//   clk    system clock
//   reset  asynchronous, active-high; loads SEED (a zero seed becomes 5'h01)
//   q      current LFSR value, never zero
module lfsr5
    import mole_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 5'h01
) (
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] q
);

    // The all-zero state is a lock-up state for this LFSR.
    localparam logic [LFSR_W-1:0] SEED_FIX = (SEED == '0) ? LFSR_W'(1) : SEED;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= SEED_FIX;
        end else begin
            q <= {q[LFSR_W-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
        end
    end

endmodule

// File: rtl/mole_led_generator.sv
// mole_led_generator: runs a game of NUM_ROUNDS rounds; each round lights one
// pseudo-random LED (never the same as the previous round) for a
// difficulty-scaled window, then keeps all LEDs dark for GAP_CYCLES.
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    mole_led_generator_if.slave (start/difficulty in, game status out)
module mole_led_generator
    import mole_pkg::*;
#(
    parameter int          SHOW_CYCLES = 50_000_000,
    parameter int          GAP_CYCLES  = 12_500_000,
    parameter int          NUM_ROUNDS  = 15,
    parameter logic [4:0]  LFSR_SEED   = 5'h01
) (
    input  logic                 clk,
    input  logic                 reset,
    mole_led_generator_if.slave  bus
);

    localparam int MAX_CYCLES = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] ST_IDLE = 3'(IDLE);
    localparam logic [2:0] ST_PICK = 3'(PICK);
    localparam logic [2:0] ST_SHOW = 3'(SHOW);
    localparam logic [2:0] ST_GAP  = 3'(GAP);
    localparam logic [2:0] ST_DONE = 3'(DONE);

    localparam logic [TW-1:0]     GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [3:0]        LAST_RND  = 4'(NUM_ROUNDS);
    localparam logic [N_LEDS-1:0] ONE       = N_LEDS'(1);
    localparam logic [4:0]        NO_PREV   = 5'h1F;

    logic [2:0]        state;
    logic [TW-1:0]     timer;
    logic [4:0]        prev_idx;
    logic [N_LEDS-1:0] leds;
    logic              round_active;
    logic              new_round;
    logic [3:0]        round_num;
    logic              game_over;

    logic [LFSR_W-1:0] lfsr_q;
    logic [4:0]        cand;
    logic              accept;
    logic [TW-1:0]     show_load;

    lfsr5 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    // LFSR never reads zero, so the candidate spans 0..30; out-of-range or
    // repeated candidates are skipped and retried on the next LFSR value.
    assign cand      = lfsr_q - 5'd1;
    assign accept    = (cand < 5'(N_LEDS)) && (cand != prev_idx);
    assign show_load = TW'(window_len(32'(SHOW_CYCLES), bus.difficulty) - 32'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            timer        <= '0;
            prev_idx     <= NO_PREV;
            leds         <= '0;
            round_active <= 1'b0;
            new_round    <= 1'b0;
            round_num    <= 4'd0;
            game_over    <= 1'b0;
        end else begin
            new_round <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        prev_idx <= NO_PREV;
                        state    <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    if (accept) begin
                        leds         <= ONE << cand;
                        round_active <= 1'b1;
                        new_round    <= 1'b1;
                        prev_idx     <= cand;
                        timer        <= show_load;
                        state        <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (timer == '0) begin
                        leds         <= '0;
                        round_active <= 1'b0;
                        timer        <= GAP_LOAD;
                        state        <= ST_GAP;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_GAP: begin
                    if (timer == '0) begin
                        round_num <= round_num + 4'd1;
                        if (round_num + 4'd1 == LAST_RND) begin
                            game_over <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_PICK;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.start) begin
                        round_num <= 4'd0;
                        game_over <= 1'b0;
                        prev_idx  <= NO_PREV;
                        state     <= ST_PICK;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.leds         = leds;
    assign bus.round_active = round_active;
    assign bus.new_round    = new_round;
    assign bus.round_num    = round_num;
    assign bus.game_over    = game_over;
    assign bus.fsm_state    = state;

endmodule
